ln_stage2_ctrl: RTL and testbench

Sequencer for the LayerNorm stage-2 datapath (`LN_calculation`). After a start pulse it walks one tensor in burst-major order: h, then W-burst, then channel group, then pixel within the burst. For each beat it issues a feature-buffer read, a statistics read (mean, reciprocal sqrt) and a weight/bias read. Issue is paced by a credit counter against the downstream output FIFO. The block reports completion once every issued beat has returned from the fixed-latency datapath.

---
 rtl/ln_ctrl_pkg.sv | 15 +
 rtl/ln_wrap_cnt.sv | 26 ++
 rtl/ln_stage2_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_ln_stage2_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ln_ctrl_pkg.sv
// Shared types and default sizing for the LayerNorm stage-2 sequencer.
package ln_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } ln_state_e;

   localparam int DEF_BURST_LEN = 16;
   localparam int DEF_CREDITS   = 32;
   localparam int DEF_PIPE_LAT  = 5;

endpackage

// File: rtl/ln_wrap_cnt.sv
// Wrap counter: counts 0..max_val on en, wraps to 0, synchronous clear.
module ln_wrap_cnt #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] max_val,
   output logic [W-1:0] cnt,
   output logic         is_max
);

   assign is_max = (cnt == max_val);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= is_max ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/ln_stage2_ctrl.sv
// Stage-2 LayerNorm sequencer: walks h / W-burst / channel group / pixel,
// paces issue with output-FIFO credits and reports done after the pipe drains.
module ln_stage2_ctrl
   import ln_ctrl_pkg::*;
#(
   parameter int BURST_LEN = DEF_BURST_LEN,
   parameter int LOG2_W    = 12,
   parameter int LOG2_H    = 12,
   parameter int LOG2_CHT  = 8,
   parameter int PIPE_LAT  = DEF_PIPE_LAT,
   parameter int CREDITS   = DEF_CREDITS
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [LOG2_CHT-1:0] CH_in_div_Tout,
   input  logic [LOG2_H-1:0]   h_in,
   input  logic [LOG2_W-1:0]   w_in,
   input  logic                feat_rdy,
   output logic                feat_issue,
   output logic [LOG2_H-1:0]   feat_h,
   output logic [LOG2_W-1:0]   feat_w,
   output logic [LOG2_CHT-1:0] feat_chg,
   output logic                new_chg,
   input  logic                dp_out_vld,
   input  logic                out_pop,
   output logic                busy,
   output logic                done,
   output logic                err_ovf
);

   localparam int LOG2_BURST = $clog2(BURST_LEN);
   localparam int WBW        = LOG2_W - LOG2_BURST;
   localparam int CRW        = $clog2(CREDITS + 1);
   localparam int IFW        = $clog2(CREDITS + PIPE_LAT + 1) + 1;

   ln_state_e state;

   logic [LOG2_CHT-1:0]   cht_q;
   logic [LOG2_H-1:0]     h_q;
   logic [LOG2_W-1:0]     w_q;

   logic [LOG2_BURST-1:0] w_cnt;
   logic [LOG2_CHT-1:0]   ch_cnt;
   logic [WBW-1:0]        wb_cnt;
   logic [LOG2_H-1:0]     h_cnt;
   logic                  w_max, ch_max, wb_max, h_max;

   logic [LOG2_BURST-1:0] w_low;
   logic [LOG2_BURST-1:0] cur_len;
   logic [WBW-1:0]        wb_max_val;

   logic [CRW-1:0]        credit, credit_nxt;
   logic [IFW-1:0]        inflight, inflight_nxt;
   logic                  ovf_hit;

   logic start_acc;
   logic last_beat;

   assign start_acc = (state == ST_IDLE) && start;

   // feat_issue is a one-cycle strobe: a beat transfers in every cycle it is
   // high, which requires RUN, feat_rdy from the buffer and a free FIFO credit.
   assign feat_issue = (state == ST_RUN) && feat_rdy && (credit != '0);

   assign w_low      = w_q[LOG2_BURST-1:0];
   assign wb_max_val = WBW'((w_q - 1'b1) >> LOG2_BURST);
   // A width that is a whole number of bursts leaves the last burst full length.
   assign cur_len    = (wb_max && (w_low != '0)) ? w_low - 1'b1
                                                 : LOG2_BURST'(BURST_LEN - 1);

   ln_wrap_cnt #(.W(LOG2_BURST)) u_w_cnt (
      .clk(clk), .rst_n(rst_n), .clr(start_acc), .en(feat_issue),
      .max_val(cur_len), .cnt(w_cnt), .is_max(w_max)
   );

   ln_wrap_cnt #(.W(LOG2_CHT)) u_ch_cnt (
      .clk(clk), .rst_n(rst_n), .clr(start_acc), .en(feat_issue && w_max),
      .max_val(cht_q - 1'b1), .cnt(ch_cnt), .is_max(ch_max)
   );

   ln_wrap_cnt #(.W(WBW)) u_wb_cnt (
      .clk(clk), .rst_n(rst_n), .clr(start_acc),
      .en(feat_issue && w_max && ch_max),
      .max_val(wb_max_val), .cnt(wb_cnt), .is_max(wb_max)
   );

   ln_wrap_cnt #(.W(LOG2_H)) u_h_cnt (
      .clk(clk), .rst_n(rst_n), .clr(start_acc),
      .en(feat_issue && w_max && ch_max && wb_max),
      .max_val(h_q - 1'b1), .cnt(h_cnt), .is_max(h_max)
   );

   assign last_beat = feat_issue && w_max && ch_max && wb_max && h_max;

   assign feat_h   = h_cnt;
   assign feat_w   = {wb_cnt, w_cnt};
   assign feat_chg = ch_cnt;
   assign new_chg  = (state == ST_RUN) && (w_cnt == '0);

   always_comb begin
      credit_nxt = credit;
      if (feat_issue && !out_pop) begin
         credit_nxt = credit - 1'b1;
      end else if (out_pop && !feat_issue && (credit != CRW'(CREDITS))) begin
         credit_nxt = credit + 1'b1;
      end
   end

   always_comb begin
      inflight_nxt = inflight;
      ovf_hit      = 1'b0;
      if (feat_issue && !dp_out_vld) begin
         inflight_nxt = inflight + 1'b1;
      end else if (dp_out_vld && !feat_issue) begin
         if (inflight == '0) begin
            ovf_hit = 1'b1;
         end else begin
            inflight_nxt = inflight - 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         credit   <= CRW'(CREDITS);
         inflight <= '0;
         err_ovf  <= 1'b0;
      end else begin
         credit   <= credit_nxt;
         inflight <= inflight_nxt;
         if (start_acc) begin
            err_ovf <= 1'b0;
         end else if (ovf_hit) begin
            err_ovf <= 1'b1;
         end
      end
   end

   // done is raised on the edge that retires the last beat, so it appears
   // PIPE_LAT+1 cycles after the final issue.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         cht_q <= '0;
         h_q   <= '0;
         w_q   <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state <= ST_RUN;
                  busy  <= 1'b1;
                  cht_q <= CH_in_div_Tout;
                  h_q   <= h_in;
                  w_q   <= w_in;
               end
            end
            ST_RUN: begin
               if (last_beat) begin
                  state <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (inflight_nxt == '0) begin
                  state <= ST_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ln_stage2_ctrl.sv
// Scoreboard bench for ln_stage2_ctrl: expected beats queued per run, checked
// by a monitor on every feat_issue; fixed-latency datapath model returns beats.
module tb_ln_stage2_ctrl;

   localparam int BL = 16;
   localparam int LW = 12;
   localparam int LH = 12;
   localparam int LC = 8;
   localparam int PL = 5;
   localparam int CR = 4;
   localparam int BW = LH + LW + LC + 1;

   logic          clk      = 1'b0;
   logic          rst_n    = 1'b0;
   logic          start    = 1'b0;
   logic [LC-1:0] cht      = 8'd1;
   logic [LH-1:0] h_in     = 12'd1;
   logic [LW-1:0] w_in     = 12'd1;
   logic          feat_rdy = 1'b1;
   logic          out_pop  = 1'b1;
   logic          spur     = 1'b0;
   logic          tog_rdy  = 1'b0;
   logic          dp_out_vld;

   logic          feat_issue, new_chg, busy, done, err_ovf;
   logic [LH-1:0] feat_h;
   logic [LW-1:0] feat_w;
   logic [LC-1:0] feat_chg;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int issues = 0;
   int returns = 0;
   int done_cnt = 0;
   int done_cyc = 0;
   int ret_at_done = 0;
   int no_rdy = 0;

   logic [BW-1:0] exp_q[$];
   logic [BW-1:0] mon_act, mon_exp;
   logic [PL-1:0] dp_sr;

   ln_stage2_ctrl #(
      .BURST_LEN(BL), .LOG2_W(LW), .LOG2_H(LH), .LOG2_CHT(LC),
      .PIPE_LAT(PL), .CREDITS(CR)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .CH_in_div_Tout(cht), .h_in(h_in), .w_in(w_in),
      .feat_rdy(feat_rdy), .feat_issue(feat_issue),
      .feat_h(feat_h), .feat_w(feat_w), .feat_chg(feat_chg),
      .new_chg(new_chg), .dp_out_vld(dp_out_vld), .out_pop(out_pop),
      .busy(busy), .done(done), .err_ovf(err_ovf)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   // ---------------- datapath model ----------------
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dp_sr <= '0;
      end else begin
         dp_sr <= {dp_sr[PL-2:0], feat_issue};
         if (dp_sr[PL-1]) returns <= returns + 1;
      end
   end
   assign dp_out_vld = dp_sr[PL-1] | spur;

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      if (rst_n && feat_issue) begin
         issues = issues + 1;
         if (!feat_rdy) no_rdy = no_rdy + 1;
         mon_act = {feat_h, feat_w, feat_chg, new_chg};
         total = total + 1;
         if (exp_q.size() == 0) begin
            bad = bad + 1;
            $display("FAIL beat_unexpected got=%h want=none", mon_act);
         end else begin
            mon_exp = exp_q.pop_front();
            if (mon_act !== mon_exp) begin
               bad = bad + 1;
               $display("FAIL beat got h=%0d w=%0d chg=%0d new=%0d want h=%0d w=%0d chg=%0d new=%0d",
                        mon_act[BW-1 -: LH], mon_act[LW+LC -: LW], mon_act[LC:1], mon_act[0],
                        mon_exp[BW-1 -: LH], mon_exp[LW+LC -: LW], mon_exp[LC:1], mon_exp[0]);
            end
         end
      end
      if (done) begin
         done_cnt    = done_cnt + 1;
         done_cyc    = cyc;
         ret_at_done = returns;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
      total = total + 1;
      if (act !== want) begin
         bad = bad + 1;
         $display("FAIL %s got=%0d want=%0d", name, act, want);
      end
   endtask

   task automatic push_seq(input int h, input int w, input int c);
      int nb, len;
      logic [LH-1:0] eh;
      logic [LW-1:0] ew;
      logic [LC-1:0] ec;
      logic          en;
      nb = (w + BL - 1) / BL;
      for (int hh = 0; hh < h; hh++) begin
         for (int b = 0; b < nb; b++) begin
            len = ((b == nb - 1) && ((w % BL) != 0)) ? (w % BL) : BL;
            for (int cc = 0; cc < c; cc++) begin
               for (int p = 0; p < len; p++) begin
                  eh = LH'(hh);
                  ew = LW'(b * BL + p);
                  ec = LC'(cc);
                  en = (p == 0);
                  exp_q.push_back({eh, ew, ec, en});
               end
            end
         end
      end
   endtask

   task automatic start_cfg(input int h, input int w, input int c, output int t0);
      h_in = LH'(h);
      w_in = LW'(w);
      cht  = LC'(c);
      push_seq(h, w, c);
      start = 1'b1;
      t0 = cyc;
      tick();
      start = 1'b0;
      check("busy_after_start", busy, 1);
      check("err_clear_on_start", err_ovf, 0);
   endtask

   task automatic wait_done(input int d0, input int budget, input int mid_at);
      for (int k = 0; k < budget && done_cnt == d0; k++) begin
         if (tog_rdy) feat_rdy = ~feat_rdy;
         if (k == mid_at) start = 1'b1;
         tick();
         start = 1'b0;
      end
   endtask

   task automatic run(input int h, input int w, input int c, input bit timed, input int mid_at);
      int t0, d0, i0, r0, n;
      n  = h * w * c;
      d0 = done_cnt;
      i0 = issues;
      r0 = returns;
      start_cfg(h, w, c, t0);
      wait_done(d0, n * 4 + 60, mid_at);
      check("done_seen", done_cnt - d0, 1);
      if (timed) check("done_cycle", done_cyc - t0, n + PL + 1);
      check("issue_count", issues - i0, n);
      check("returns_at_done", ret_at_done - r0, n);
      repeat (3) tick();
      check("busy_after_done", busy, 0);
      check("single_done", done_cnt - d0, 1);
      check("queue_empty", exp_q.size(), 0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int t0, d0, i0, r0;

      repeat (3) tick();
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_issue", feat_issue, 0);
      check("rst_new_chg", new_chg, 0);
      check("rst_err", err_ovf, 0);
      check("rst_addr", {feat_h, feat_w, feat_chg}, 0);
      rst_n = 1'b1;
      tick();

      // one full burst, two channel groups
      run(1, 16, 2, 1'b1, -1);
      // short last burst of 4 pixels
      run(2, 20, 1, 1'b1, -1);
      // width a multiple of the burst
      run(1, 32, 2, 1'b1, -1);

      // credit starvation then one pop per cycle
      out_pop = 1'b0;
      d0 = done_cnt;
      i0 = issues;
      r0 = returns;
      start_cfg(1, 16, 1, t0);
      repeat (20) tick();
      check("stall_issues", issues - i0, CR);
      check("stall_no_done", done_cnt - d0, 0);
      out_pop = 1'b1;
      wait_done(d0, 200, -1);
      check("stall_done_seen", done_cnt - d0, 1);
      check("stall_issue_count", issues - i0, 16);
      check("stall_returns_at_done", ret_at_done - r0, 16);
      check("stall_queue_empty", exp_q.size(), 0);
      repeat (6) tick();

      // feat_rdy toggling, stray start mid-run
      tog_rdy = 1'b1;
      run(1, 20, 1, 1'b0, 10);
      tog_rdy  = 1'b0;
      feat_rdy = 1'b1;
      check("no_issue_without_rdy", no_rdy, 0);

      // reset while draining
      d0 = done_cnt;
      i0 = issues;
      start_cfg(1, 16, 1, t0);
      for (int k = 0; k < 100 && (issues - i0) < 16; k++) tick();
      check("drain_reached", issues - i0, 16);
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_done", done, 0);
      check("mid_rst_issue", feat_issue, 0);
      check("mid_rst_new_chg", new_chg, 0);
      check("mid_rst_err", err_ovf, 0);
      check("mid_rst_addr", {feat_h, feat_w, feat_chg}, 0);
      exp_q.delete();
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      check("no_done_after_rst", done_cnt - d0, 0);
      run(1, 20, 2, 1'b1, -1);

      // spurious datapath return with nothing in flight
      spur = 1'b1;
      tick();
      spur = 1'b0;
      check("err_ovf_set", err_ovf, 1);
      repeat (5) tick();
      check("err_ovf_sticky", err_ovf, 1);
      run(1, 16, 1, 1'b1, -1);
      check("err_ovf_stays_clear", err_ovf, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
